// File: rtl/matvec_seq.sv
// Job sequencer for the N-lane matrix-vector engine: loader, FIFO pops, MAC control, result readout.
// Latency: go->ld_start 1 cycle; unstalled job K+1+N cycles from first EXEC to first res_valid.
// Backpressure: B starvation stalls EXEC indefinitely; res_ready low holds the current result beat.
module matvec_seq #(
    parameter int N          = 8,
    parameter int K          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_W      = 3 * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   cont,
    input  logic                   abort,
    output logic                   ld_start,
    input  logic                   ld_done,
    input  logic                   b_empty,
    output logic                   b_rden,
    input  logic [N-1:0]           a_empty,
    output logic [N-1:0]           a_rden,
    output logic                   mac_en,
    output logic                   mac_clr,
    input  logic [N-1:0]           mac_en_out,
    input  logic [N*ACC_W-1:0]     mac_c,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_W-1:0]       res_data,
    output logic [$clog2(N)-1:0]   res_lane,
    output logic                   res_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [2:0]             state_dbg,
    output logic [15:0]            job_cnt
);

    localparam int LW  = $clog2(N);
    localparam int BW  = $clog2(K + 1);
    localparam int DCW = $clog2(N + 1);

    // State encoding is visible on state_dbg, so the values are fixed.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [BW-1:0]    b_cnt_q;
    logic [DCW-1:0]   drain_cnt_q;
    logic [LW-1:0]    lane_q;
    logic [ACC_W-1:0] res_buf_q [N];
    logic             done_q;
    logic             err_q;
    logic [15:0]      job_cnt_q;

    logic in_pipe;
    logic abort_take;
    logic last_pop;
    logic drain_last;
    logic last_lane;
    logic beat_acc;
    logic go_take;

    // Abort is meaningless in IDLE, so it only acts once a job is under way.
    assign abort_take = abort && (state_q != S_IDLE);
    assign go_take    = go && (state_q == S_IDLE);

    // A FIFOs keep draining through FLUSH/DRAIN because the MAC enable is pipelined per lane.
    assign in_pipe    = (state_q == S_EXEC) || (state_q == S_FLUSH) || (state_q == S_DRAIN);
    assign last_pop   = (state_q == S_EXEC) && !b_empty && (b_cnt_q == BW'(K - 1));
    assign drain_last = (state_q == S_DRAIN) && (drain_cnt_q == DCW'(1));
    assign last_lane  = (lane_q == LW'(N - 1));
    assign beat_acc   = res_valid && res_ready;

    // Control strobes decode straight from the state; B pop follows the FIFO flag in EXEC.
    assign ld_start  = (state_q == S_LOAD);
    assign mac_clr   = (state_q == S_CLEAR);
    assign b_rden    = (state_q == S_EXEC) && !b_empty;
    assign mac_en    = b_rden || (state_q == S_FLUSH);
    assign a_rden    = in_pipe ? (mac_en_out & ~a_empty) : '0;
    assign res_valid = (state_q == S_OUT);
    assign res_data  = res_valid ? res_buf_q[lane_q] : '0;
    assign res_lane  = lane_q;
    assign res_last  = res_valid && last_lane;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;
    assign job_cnt   = job_cnt_q;

    // Next-state selection; abort overrides every normal transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_LOAD;
            S_LOAD:  if (ld_done) state_d = S_CLEAR;
            S_CLEAR: state_d = S_EXEC;
            S_EXEC:  if (last_pop) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DRAIN;
            S_DRAIN: if (drain_last) state_d = S_OUT;
            S_OUT:   if (beat_acc && last_lane) state_d = cont ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_take) begin
            state_d = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // B pop counter: restarted in CLEAR, counts every accepted pop in EXEC.
    always_ff @(posedge clk) begin
        if (rst || (state_q == S_CLEAR)) begin
            b_cnt_q <= '0;
        end else if (b_rden) begin
            b_cnt_q <= b_cnt_q + 1'b1;
        end
    end

    // Drain counter: N cycles for the slowest lane's pipelined enable to retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_q <= '0;
        end else if (state_q == S_FLUSH) begin
            drain_cnt_q <= DCW'(N);
        end else if (state_q == S_DRAIN) begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
        end
    end

    // Result buffer: all lanes captured together on the edge the drain count reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                res_buf_q[i] <= '0;
            end
        end else if (drain_last && !abort_take) begin
            for (int i = 0; i < N; i++) begin
                res_buf_q[i] <= mac_c[i*ACC_W +: ACC_W];
            end
        end
    end

    // Readout lane pointer: advances per accepted beat, rewinds after the last beat or on abort.
    always_ff @(posedge clk) begin
        if (rst || abort_take) begin
            lane_q <= '0;
        end else if (beat_acc) begin
            lane_q <= last_lane ? '0 : lane_q + 1'b1;
        end
    end

    // Job completion: done pulse and job counter follow acceptance of the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            job_cnt_q <= '0;
        end else begin
            done_q <= beat_acc && last_lane && !abort_take;
            if (beat_acc && last_lane && !abort_take) begin
                job_cnt_q <= job_cnt_q + 16'd1;
            end
        end
    end

    // Sticky underflow flag: a lane wanted data its A FIFO did not have; cleared by the next go.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (go_take) begin
            err_q <= 1'b0;
        end else if (in_pipe && |(mac_en_out & a_empty)) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matvec_seq.sv
// Self-checking bench for matvec_seq with N=K=8.
// Inputs are driven 1 time unit after the rising edge and outputs sampled 1 unit later.
// A delay-line stand-in for the MAC array feeds mac_en_out (lane i = mac_en delayed i+1 cycles).
module tb_matvec_seq;
    localparam int N  = 8;
    localparam int K  = 8;
    localparam int DW = 8;
    localparam int AW = 3 * DW;
    localparam int LW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst, go, cont, abort, ld_done, b_empty, res_ready;
    logic [N-1:0]  a_empty;
    logic [N-1:0]  mac_en_out;
    logic [N*AW-1:0] mac_c;
    logic          ld_start, b_rden, mac_en, mac_clr, res_valid, res_last, busy, done, err;
    logic [N-1:0]  a_rden;
    logic [AW-1:0] res_data;
    logic [LW-1:0] res_lane;
    logic [2:0]    state_dbg;
    logic [15:0]   job_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] jobs_exp = '0;
    logic        err_exp = 1'b0;
    logic [N-1:0] en_sh = '0;
    int          tc, tv, td;

    matvec_seq #(.N(N), .K(K), .DATA_WIDTH(DW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .go(go), .cont(cont), .abort(abort),
        .ld_start(ld_start), .ld_done(ld_done), .b_empty(b_empty), .b_rden(b_rden),
        .a_empty(a_empty), .a_rden(a_rden), .mac_en(mac_en), .mac_clr(mac_clr),
        .mac_en_out(mac_en_out), .mac_c(mac_c), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_lane(res_lane), .res_last(res_last), .busy(busy),
        .done(done), .err(err), .state_dbg(state_dbg), .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_sh <= rst ? '0 : {en_sh[N-2:0], mac_en};
    assign mac_en_out = en_sh;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk(tag, 64'({ld_start, b_rden, mac_en, mac_clr, res_valid, res_last, busy, a_rden}), 64'd0);
    endtask

    task automatic reset_chk();
        idle_chk("reset_outputs");
        chk("reset_state", 64'(state_dbg), 64'd0);
        chk("reset_job_cnt", 64'(job_cnt), 64'd0);
        chk("reset_err_done", 64'({err, done}), 64'd0);
        chk("reset_res", 64'({res_lane, res_data}), 64'd0);
    endtask

    // One job: ld_done in cycle ld_dly (go is cycle 0); stall_pct<0 selects the fixed
    // 3-cycle starvation after the 4th pop; bad_lane>=0 empties that A FIFO after EXEC.
    task automatic run_job(input int ld_dly, input int stall_pct, input bit rdy_rand,
                           input int bad_lane, input bit cont_v, input bit from_load,
                           input int rst_beat, output int t_clr, output int t_val, output int t_done);
        logic [AW-1:0] exp_beats [N];
        int t, pops, rd_cnt, en_cyc, exec_cyc, stall_run, lane, guard;
        t_clr = -1; t_val = -1; t_done = -1;
        cont = cont_v;
        for (int i = 0; i < N; i++) begin
            exp_beats[i] = AW'($urandom);
            mac_c[i*AW +: AW] = exp_beats[i];
        end
        t = 1;
        if (!from_load) begin
            tick(); go = 1'b1; settle();
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_err_sticky", 64'(err), 64'(err_exp));
            err_exp = 1'b0;
            tick(); go = 1'b0; settle();
        end
        chk("load_ld_start", 64'(ld_start), 64'd1);
        chk("load_state", 64'(state_dbg), 64'd1);
        chk("load_err", 64'(err), 64'(err_exp));
        while (t < ld_dly) begin
            tick(); t++;
            ld_done = (t == ld_dly);
            settle();
            chk("load_hold", 64'({ld_start, mac_clr}), 64'b10);
        end
        tick(); t++; ld_done = 1'b0; b_empty = 1'b0; settle();
        chk("clear_mac_clr", 64'({mac_clr, b_rden, mac_en}), 64'b100);
        t_clr = t;
        pops = 0; rd_cnt = 0; en_cyc = 0; exec_cyc = 0; stall_run = 0; guard = 0;
        while (pops < K && guard < 400) begin
            tick(); t++; guard++;
            if (stall_pct < 0) begin
                b_empty = (pops == 4 && stall_run < 3);
                if (b_empty) stall_run++;
            end else begin
                b_empty = ($urandom_range(99) < stall_pct);
            end
            settle();
            exec_cyc++;
            chk("exec_b_rden", 64'(b_rden), 64'(!b_empty));
            chk("exec_mac_en", 64'({mac_en, mac_clr}), 64'({!b_empty, 1'b0}));
            chk("exec_a_rden", 64'(a_rden), 64'(mac_en_out & ~a_empty));
            rd_cnt += int'(b_rden);
            en_cyc += int'(mac_en);
            if (|(mac_en_out & a_empty)) err_exp = 1'b1;
            if (!b_empty) pops++;
        end
        tick(); t++;
        b_empty = 1'($urandom_range(1));
        res_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
        if (bad_lane >= 0) a_empty[bad_lane] = 1'b1;
        settle();
        chk("flush_mac_en", 64'({mac_en, b_rden}), 64'b10);
        chk("flush_a_rden", 64'(a_rden), 64'(mac_en_out & ~a_empty));
        en_cyc += int'(mac_en);
        if (|(mac_en_out & a_empty)) err_exp = 1'b1;
        chk("mac_en_cycles", 64'(en_cyc), 64'(K + 1));
        chk("b_rden_pulses", 64'(rd_cnt), 64'(K));
        guard = 0;
        do begin
            tick(); t++; guard++;
            b_empty = 1'($urandom_range(1));
            go = 1'($urandom_range(1));
            res_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
            settle();
            if (!res_valid) begin
                chk("drain_quiet", 64'({mac_en, b_rden, mac_clr, ld_start}), 64'd0);
                chk("drain_a_rden", 64'(a_rden), 64'(mac_en_out & ~a_empty));
                if (|(mac_en_out & a_empty)) err_exp = 1'b1;
            end
        end while (!res_valid && guard < 100);
        go = 1'b0;
        a_empty = '0;
        t_val = t;
        chk("first_valid_latency", 64'(t - (t_clr + 1)), 64'(exec_cyc + 1 + N));
        chk("out_a_rden", 64'(a_rden), 64'd0);
        for (int i = 0; i < N; i++) mac_c[i*AW +: AW] = AW'($urandom);
        lane = 0; guard = 0;
        forever begin
            chk("out_valid", 64'(res_valid), 64'd1);
            chk("out_lane", 64'(res_lane), 64'(lane));
            chk("out_data", 64'(res_data), 64'(exp_beats[lane]));
            chk("out_last", 64'(res_last), 64'(lane == N - 1));
            chk("out_no_done", 64'(done), 64'd0);
            chk("out_err", 64'(err), 64'(err_exp));
            if (res_ready) begin
                if (lane == N - 1) break;
                lane++;
                if (lane == rst_beat) return;
            end
            guard++;
            if (guard > 200) begin
                chk("out_timeout_lane", 64'(lane), 64'(N - 1));
                return;
            end
            tick(); t++;
            res_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
            settle();
        end
        tick(); t++; res_ready = 1'b0; settle();
        t_done = t;
        jobs_exp++;
        chk("done_pulse", 64'(done), 64'd1);
        chk("job_cnt", 64'(job_cnt), 64'(jobs_exp));
        chk("err_after_job", 64'(err), 64'(err_exp));
        if (cont_v) begin
            chk("cont_restart", 64'({ld_start, state_dbg}), 64'({1'b1, 3'd1}));
        end else begin
            chk("end_idle", 64'({ld_start, res_valid, state_dbg}), 64'd0);
            tick(); settle();
            chk("done_one_cycle", 64'(done), 64'd0);
            idle_chk("idle_after_job");
            chk("err_in_idle", 64'(err), 64'(err_exp));
        end
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; cont = 1'b0; abort = 1'b0; ld_done = 1'b0;
        b_empty = 1'b1; res_ready = 1'b0; a_empty = '0; mac_c = '0;
        repeat (3) tick();
        rst = 1'b0; settle();
        reset_chk();

        // Abort in the 3rd EXEC cycle.
        tick(); go = 1'b1; settle();
        tick(); go = 1'b0; settle();
        chk("abort_ld_start", 64'(ld_start), 64'd1);
        tick(); ld_done = 1'b1; b_empty = 1'b0; settle();
        tick(); ld_done = 1'b0; settle();
        chk("abort_mac_clr", 64'(mac_clr), 64'd1);
        tick(); settle();
        tick(); settle();
        tick(); abort = 1'b1; settle();
        chk("abort_in_exec", 64'({state_dbg, b_rden}), 64'({3'd3, 1'b1}));
        tick(); abort = 1'b0; b_empty = 1'b1; settle();
        chk("abort_state", 64'(state_dbg), 64'd0);
        idle_chk("abort_outputs");
        chk("abort_job_cnt", 64'(job_cnt), 64'(jobs_exp));
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            chk("abort_no_done", 64'({done, busy}), 64'd0);
        end

        // Reference timing: go at 0, ld_done at 5, no stalls, always ready.
        run_job(5, 0, 1'b0, -1, 1'b0, 1'b0, -1, tc, tv, td);
        chk("basic_mac_clr_cycle", 64'(tc), 64'd6);
        chk("basic_first_valid", 64'(tv), 64'd24);
        chk("basic_done_cycle", 64'(td), 64'd32);

        // Three starved cycles after the 4th pop.
        run_job(5, -1, 1'b0, -1, 1'b0, 1'b0, -1, tc, tv, td);
        chk("stall_first_valid", 64'(tv), 64'd27);

        // Randomly toggling res_ready through readout.
        run_job(3, 0, 1'b1, -1, 1'b0, 1'b0, -1, tc, tv, td);

        // Lane 3 A FIFO empty while its pipelined enable is live.
        run_job(4, 0, 1'b0, 3, 1'b0, 1'b0, -1, tc, tv, td);
        chk("underflow_err_sticky", 64'(err), 64'd1);

        // Randomised jobs; the first go also clears the sticky error.
        for (int j = 0; j < 4; j++) begin
            run_job($urandom_range(2, 6), 35, 1'b1, -1, 1'b0, 1'b0, -1, tc, tv, td);
        end

        // Continuous mode: second job restarts without go, then reset mid-readout.
        run_job(3, 20, 1'b0, -1, 1'b1, 1'b0, -1, tc, tv, td);
        run_job(2, 0, 1'b1, -1, 1'b1, 1'b1, 3, tc, tv, td);
        chk("cont_job_cnt", 64'(job_cnt), 64'(jobs_exp));
        tick(); rst = 1'b1; cont = 1'b0; res_ready = 1'b0; settle();
        tick(); rst = 1'b0; settle();
        jobs_exp = '0;
        err_exp = 1'b0;
        reset_chk();

        // Fresh job after reset counts from zero again.
        run_job(2, 10, 1'b1, -1, 1'b0, 1'b0, -1, tc, tv, td);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
